// File: rtl/alu_rs_pkg.sv
// ALU reservation station: shared widths, opcode groups and entry record.
// Imported by the station top and its oldest-ready picker.
package alu_rs_pkg;

  localparam int RS_DATA_W = 32;
  localparam int RS_TAG_W  = 3;
  localparam int RS_AGE_W  = 3;

  localparam logic [4:0] OP_MUL_LO = 5'd9;
  localparam logic [4:0] OP_MUL_HI = 5'd12;
  localparam logic [4:0] OP_DIV_LO = 5'd13;
  localparam logic [4:0] OP_DIV_HI = 5'd16;

  typedef struct packed {
    logic                 valid;
    logic [4:0]           opcode;
    logic [2:0]           branch_op;
    logic [RS_TAG_W-1:0]  tag;
    logic [4:0]           dest_reg;
    logic [RS_DATA_W-1:0] op1;
    logic                 op1_rdy;
    logic [RS_TAG_W-1:0]  op1_tag;
    logic [RS_DATA_W-1:0] op2;
    logic                 op2_rdy;
    logic [RS_TAG_W-1:0]  op2_tag;
    logic [RS_AGE_W-1:0]  age;
  } rs_entry_t;

  function automatic logic is_div(logic [4:0] op);
    return (op >= OP_DIV_LO) && (op <= OP_DIV_HI);
  endfunction

  function automatic logic is_mul(logic [4:0] op);
    return (op >= OP_MUL_LO) && (op <= OP_MUL_HI);
  endfunction

endpackage

// File: rtl/alu_rs_select.sv
// Oldest-ready picker: returns the ready entry with the largest age.
// Ages are unique among valid entries, so no tie-break is needed.
module alu_rs_select
  import alu_rs_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = 2
) (
  input  logic [DEPTH-1:0]          ready,
  input  logic [DEPTH*RS_AGE_W-1:0] ages,
  output logic                      found,
  output logic [IDX_W-1:0]          idx
);

  logic [RS_AGE_W-1:0] best;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    best  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] &&
          (!found || ages[i*RS_AGE_W +: RS_AGE_W] > best)) begin
        found = 1'b1;
        idx   = i[IDX_W-1:0];
        best  = ages[i*RS_AGE_W +: RS_AGE_W];
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: dispatch, CDB wakeup, oldest-first issue.
// A divide issue blocks the next cycle until fu_busy can take over.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int DATA_WIDTH = RS_DATA_W,
  parameter int TAG_WIDTH  = RS_TAG_W,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  disp_valid,
  output logic                  disp_ready,
  input  logic [4:0]            disp_opcode,
  input  logic [2:0]            disp_branch_op,
  input  logic [TAG_WIDTH-1:0]  disp_tag,
  input  logic [4:0]            disp_dest_reg,
  input  logic [DATA_WIDTH-1:0] disp_op1,
  input  logic [DATA_WIDTH-1:0] disp_op2,
  input  logic                  disp_op1_rdy,
  input  logic                  disp_op2_rdy,
  input  logic [TAG_WIDTH-1:0]  disp_op1_tag,
  input  logic [TAG_WIDTH-1:0]  disp_op2_tag,
  input  logic                  cdb_valid,
  input  logic [TAG_WIDTH-1:0]  cdb_tag,
  input  logic [DATA_WIDTH-1:0] cdb_result,
  input  logic                  fu_busy,
  output logic                  issue_start,
  output logic [4:0]            issue_opcode,
  output logic [2:0]            issue_branch_op,
  output logic [DATA_WIDTH-1:0] issue_op1,
  output logic [DATA_WIDTH-1:0] issue_op2,
  output logic [TAG_WIDTH-1:0]  issue_tag,
  output logic [4:0]            issue_dest_reg
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [RS_AGE_W-1:0] AGE_MAX = RS_AGE_W'(DEPTH - 1);

  rs_entry_t ent     [DEPTH];
  rs_entry_t ent_nxt [DEPTH];
  rs_entry_t new_ent;
  logic      hold;

  logic [DEPTH-1:0]          vld;
  logic [DEPTH-1:0]          cand;
  logic [DEPTH*RS_AGE_W-1:0] ages;
  logic [IDX_W-1:0]          free_idx;
  logic [IDX_W-1:0]          sel_idx;
  logic                      found;
  logic                      issue_go;
  logic                      disp_acc;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      vld[i]  = ent[i].valid;
      cand[i] = ent[i].valid && ent[i].op1_rdy && ent[i].op2_rdy;
      ages[i*RS_AGE_W +: RS_AGE_W] = ent[i].age;
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!vld[i]) free_idx = i[IDX_W-1:0];
    end
  end

  alu_rs_select #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_select (
    .ready (cand),
    .ages  (ages),
    .found (found),
    .idx   (sel_idx)
  );

  assign disp_ready = ~&vld;
  assign disp_acc   = disp_valid && disp_ready && !flush;
  assign issue_go   = found && !fu_busy && !hold && !flush;

  // Operands matching a same-cycle broadcast enter already ready.
  always_comb begin
    new_ent           = '0;
    new_ent.valid     = 1'b1;
    new_ent.opcode    = disp_opcode;
    new_ent.branch_op = disp_branch_op;
    new_ent.tag       = disp_tag;
    new_ent.dest_reg  = disp_dest_reg;
    new_ent.op1       = disp_op1;
    new_ent.op1_rdy   = disp_op1_rdy;
    new_ent.op1_tag   = disp_op1_tag;
    new_ent.op2       = disp_op2;
    new_ent.op2_rdy   = disp_op2_rdy;
    new_ent.op2_tag   = disp_op2_tag;
    if (cdb_valid && !disp_op1_rdy && disp_op1_tag == cdb_tag) begin
      new_ent.op1     = cdb_result;
      new_ent.op1_rdy = 1'b1;
    end
    if (cdb_valid && !disp_op2_rdy && disp_op2_tag == cdb_tag) begin
      new_ent.op2     = cdb_result;
      new_ent.op2_rdy = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_nxt[i] = ent[i];
      if (cdb_valid && ent[i].valid) begin
        if (!ent[i].op1_rdy && ent[i].op1_tag == cdb_tag) begin
          ent_nxt[i].op1     = cdb_result;
          ent_nxt[i].op1_rdy = 1'b1;
        end
        if (!ent[i].op2_rdy && ent[i].op2_tag == cdb_tag) begin
          ent_nxt[i].op2     = cdb_result;
          ent_nxt[i].op2_rdy = 1'b1;
        end
      end
      if (ent[i].valid) begin
        if (issue_go && sel_idx == i[IDX_W-1:0]) begin
          ent_nxt[i].valid = 1'b0;
        end else begin
          if (issue_go && ent[i].age > ent[sel_idx].age)
            ent_nxt[i].age = ent[i].age - 1'b1;
          if (disp_acc && ent_nxt[i].age != AGE_MAX)
            ent_nxt[i].age = ent_nxt[i].age + 1'b1;
        end
      end
      if (disp_acc && free_idx == i[IDX_W-1:0])
        ent_nxt[i] = new_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      hold            <= 1'b0;
      issue_start     <= 1'b0;
      issue_opcode    <= '0;
      issue_branch_op <= '0;
      issue_op1       <= '0;
      issue_op2       <= '0;
      issue_tag       <= '0;
      issue_dest_reg  <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      hold        <= 1'b0;
      issue_start <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= ent_nxt[i];
      hold        <= issue_go && is_div(ent[sel_idx].opcode);
      issue_start <= issue_go;
      if (issue_go) begin
        issue_opcode    <= ent[sel_idx].opcode;
        issue_branch_op <= ent[sel_idx].branch_op;
        issue_op1       <= ent[sel_idx].op1;
        issue_op2       <= ent[sel_idx].op2;
        issue_tag       <= ent[sel_idx].tag;
        issue_dest_reg  <= ent[sel_idx].dest_reg;
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios plus random traffic
// against an in-order queue model of the station.
module tb_alu_rs;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, flush, disp_valid, disp_ready;
  logic [4:0]  disp_opcode, disp_dest_reg;
  logic [2:0]  disp_branch_op, disp_tag;
  logic [31:0] disp_op1, disp_op2;
  logic        disp_op1_rdy, disp_op2_rdy;
  logic [2:0]  disp_op1_tag, disp_op2_tag;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [31:0] cdb_result;
  logic        fu_busy, issue_start;
  logic [4:0]  issue_opcode, issue_dest_reg;
  logic [2:0]  issue_branch_op, issue_tag;
  logic [31:0] issue_op1, issue_op2;

  always #5 clk = ~clk;

  alu_rs #(.DATA_WIDTH(32), .TAG_WIDTH(3), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_opcode(disp_opcode), .disp_branch_op(disp_branch_op),
    .disp_tag(disp_tag), .disp_dest_reg(disp_dest_reg),
    .disp_op1(disp_op1), .disp_op2(disp_op2),
    .disp_op1_rdy(disp_op1_rdy), .disp_op2_rdy(disp_op2_rdy),
    .disp_op1_tag(disp_op1_tag), .disp_op2_tag(disp_op2_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_result(cdb_result),
    .fu_busy(fu_busy), .issue_start(issue_start),
    .issue_opcode(issue_opcode), .issue_branch_op(issue_branch_op),
    .issue_op1(issue_op1), .issue_op2(issue_op2),
    .issue_tag(issue_tag), .issue_dest_reg(issue_dest_reg)
  );

  typedef struct {
    logic [4:0]  opc;
    logic [2:0]  bop;
    logic [2:0]  tag;
    logic [4:0]  dst;
    logic [31:0] v1;
    logic [31:0] v2;
    logic        r1;
    logic        r2;
    logic [2:0]  t1;
    logic [2:0]  t2;
  } rec_t;

  rec_t q[$];
  rec_t m_pay;
  logic m_hold;
  logic m_start;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(string nm, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  // Model: entries kept in dispatch order; the first fully ready one issues.
  task automatic model_edge();
    int   k;
    logic room;
    rec_t r;
    if (rst) begin
      q.delete();
      m_hold  = 1'b0;
      m_start = 1'b0;
      m_pay   = '{default: '0};
    end else if (flush) begin
      q.delete();
      m_hold  = 1'b0;
      m_start = 1'b0;
    end else begin
      room = (q.size() < DEPTH);
      k = -1;
      for (int i = 0; i < q.size(); i++)
        if (k < 0 && q[i].r1 && q[i].r2) k = i;
      m_start = 1'b0;
      if (k >= 0 && !fu_busy && !m_hold) begin
        m_start = 1'b1;
        m_pay   = q[k];
        m_hold  = (q[k].opc >= 13 && q[k].opc <= 16);
        q.delete(k);
      end else begin
        m_hold = 1'b0;
      end
      if (cdb_valid) begin
        for (int i = 0; i < q.size(); i++) begin
          if (!q[i].r1 && q[i].t1 == cdb_tag) begin
            q[i].v1 = cdb_result; q[i].r1 = 1'b1;
          end
          if (!q[i].r2 && q[i].t2 == cdb_tag) begin
            q[i].v2 = cdb_result; q[i].r2 = 1'b1;
          end
        end
      end
      if (disp_valid && room) begin
        r.opc = disp_opcode;  r.bop = disp_branch_op;
        r.tag = disp_tag;     r.dst = disp_dest_reg;
        r.v1  = disp_op1;     r.r1  = disp_op1_rdy; r.t1 = disp_op1_tag;
        r.v2  = disp_op2;     r.r2  = disp_op2_rdy; r.t2 = disp_op2_tag;
        if (cdb_valid && !r.r1 && r.t1 == cdb_tag) begin
          r.v1 = cdb_result; r.r1 = 1'b1;
        end
        if (cdb_valid && !r.r2 && r.t2 == cdb_tag) begin
          r.v2 = cdb_result; r.r2 = 1'b1;
        end
        q.push_back(r);
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("issue_start", issue_start, m_start);
    check("issue_opcode", issue_opcode, m_pay.opc);
    check("issue_branch_op", issue_branch_op, m_pay.bop);
    check("issue_op1", issue_op1, m_pay.v1);
    check("issue_op2", issue_op2, m_pay.v2);
    check("issue_tag", issue_tag, m_pay.tag);
    check("issue_dest_reg", issue_dest_reg, m_pay.dst);
    check("disp_ready", disp_ready, q.size() < DEPTH);
  endtask

  task automatic idle();
    flush = 0; disp_valid = 0; cdb_valid = 0;
    disp_opcode = 0; disp_branch_op = 0; disp_tag = 0;
    disp_dest_reg = 0; disp_op1 = 0; disp_op2 = 0;
    disp_op1_rdy = 0; disp_op2_rdy = 0;
    disp_op1_tag = 0; disp_op2_tag = 0;
    cdb_tag = 0; cdb_result = 0;
  endtask

  task automatic disp(input logic [4:0] opc, input logic [2:0] tag,
                      input logic [31:0] v1, input logic r1,
                      input logic [2:0] t1, input logic [31:0] v2,
                      input logic r2, input logic [2:0] t2);
    disp_valid = 1; disp_opcode = opc; disp_tag = tag;
    disp_branch_op = tag; disp_dest_reg = {2'b0, tag} + 5'd8;
    disp_op1 = v1; disp_op1_rdy = r1; disp_op1_tag = t1;
    disp_op2 = v2; disp_op2_rdy = r2; disp_op2_tag = t2;
  endtask

  initial begin
    rst = 1; fu_busy = 0; idle();
    tick(); tick();
    check("reset_start", issue_start, 0);
    check("reset_op1", issue_op1, 0);
    check("reset_ready", disp_ready, 1);
    rst = 0;

    // single ready ADD
    disp(5'd0, 3'd2, 32'd5, 1, 3'd0, 32'd7, 1, 3'd0);
    tick(); idle(); tick();
    check("add_start", issue_start, 1);
    check("add_op1", issue_op1, 32'd5);
    check("add_op2", issue_op2, 32'd7);
    check("add_tag", issue_tag, 3'd2);

    // wakeup from CDB two cycles after dispatch
    disp(5'd1, 3'd1, 32'd0, 0, 3'd3, 32'd9, 1, 3'd0);
    tick(); idle(); tick();
    cdb_valid = 1; cdb_tag = 3'd3; cdb_result = 32'h10;
    tick();
    check("wake_nostart", issue_start, 0);
    idle(); tick();
    check("wake_start", issue_start, 1);
    check("wake_op1", issue_op1, 32'h10);

    // dispatch bypass from same-cycle broadcast
    disp(5'd2, 3'd6, 32'd3, 1, 3'd0, 32'd0, 0, 3'd5);
    cdb_valid = 1; cdb_tag = 3'd5; cdb_result = 32'hAB;
    tick(); idle(); tick();
    check("byp_start", issue_start, 1);
    check("byp_op2", issue_op2, 32'hAB);

    // fill, then drain in dispatch order
    fu_busy = 1;
    for (int i = 0; i < DEPTH; i++) begin
      disp(5'd0, 3'(i), 32'(i), 1, 3'd0, 32'd1, 1, 3'd0);
      tick();
    end
    idle();
    check("full_ready", disp_ready, 0);
    fu_busy = 0;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      check("drain_tag", issue_tag, 3'(i));
      check("drain_ready", disp_ready, 1);
    end

    // divide hold
    disp(5'd13, 3'd4, 32'd100, 1, 3'd0, 32'd7, 1, 3'd0);
    tick();
    disp(5'd0, 3'd5, 32'd1, 1, 3'd0, 32'd2, 1, 3'd0);
    tick();
    check("div_tag", issue_tag, 3'd4);
    idle(); tick();
    check("div_hold", issue_start, 0);
    fu_busy = 1; tick(); tick();
    check("div_busy", issue_start, 0);
    fu_busy = 0; tick();
    check("div_next_tag", issue_tag, 3'd5);

    // flush with three entries
    fu_busy = 1;
    for (int i = 0; i < 3; i++) begin
      disp(5'd3, 3'(i + 1), 32'd7, 1, 3'd0, 32'd7, 1, 3'd0);
      tick();
    end
    flush = 1; disp_valid = 1;
    tick();
    idle(); fu_busy = 0;
    tick(); tick();
    check("flush_start", issue_start, 0);
    check("flush_ready", disp_ready, 1);

    // reset while a wakeup is in flight
    disp(5'd0, 3'd6, 32'd11, 1, 3'd0, 32'd12, 1, 3'd0);
    tick();
    disp(5'd0, 3'd2, 32'd0, 0, 3'd1, 32'd4, 1, 3'd0);
    tick();
    idle(); rst = 1;
    cdb_valid = 1; cdb_tag = 3'd1; cdb_result = 32'h55;
    tick();
    check("rst_start", issue_start, 0);
    check("rst_op1", issue_op1, 0);
    check("rst_tag", issue_tag, 0);
    rst = 0; idle(); tick();

    // random traffic
    for (int n = 0; n < 1000; n++) begin
      rst        = ($urandom_range(0, 199) == 0);
      flush      = ($urandom_range(0, 39) == 0);
      fu_busy    = ($urandom_range(0, 9) < 3);
      disp_valid = ($urandom_range(0, 9) < 7);
      disp_opcode    = 5'($urandom_range(0, 20));
      disp_branch_op = 3'($urandom);
      disp_tag       = 3'($urandom);
      disp_dest_reg  = 5'($urandom);
      disp_op1       = $urandom;
      disp_op2       = $urandom;
      disp_op1_rdy   = 1'($urandom);
      disp_op2_rdy   = 1'($urandom);
      disp_op1_tag   = 3'($urandom);
      disp_op2_tag   = 3'($urandom);
      cdb_valid      = 1'($urandom);
      cdb_tag        = 3'($urandom);
      cdb_result     = $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
